// File: rtl/counter_ctrl.sv
// -----------------------------------------------------------------------------
// counter_ctrl
//
// Run controller for a LENGTH-bit counter. It starts, stops and terminates a
// count against a programmable period in one-shot or periodic mode, and raises
// a sticky interrupt that the host clears with an acknowledge.
//
// Optional feature macro: COUNTER_CTRL_PRESCALER_EN
//   Defined   : adds the `prescale` port and a PRESCALE_W-bit tick divider;
//               one tick every prescale+1 clocks while running.
//   Undefined : every clock spent running is a tick.
//
// Handshake: start, stop and irq_ack are single-cycle level requests sampled
// on the rising clock edge. There is no back-pressure. stop beats start in the
// same cycle. A terminal event beats irq_ack in the same cycle.
//
// Ports
//   clk       in   clock, rising edge
//   arst_b    in   asynchronous active-low reset
//   start     in   begin a run (ignored while running or with period == 0)
//   stop      in   abort a run / leave DONE
//   periodic  in   1 = periodic, 0 = one-shot; sampled with start
//   period    in   terminal count; sampled with start
//   prescale  in   tick divider; sampled with start (macro builds only)
//   irq_ack   in   clears irq
//   count     out  current count value
//   running   out  high while in RUN
//   done      out  one-cycle pulse per terminal event
//   irq       out  sticky terminal-event flag
//
// The FSM state is held in the `state` signal so it can be probed
// hierarchically.
// -----------------------------------------------------------------------------
module counter_ctrl #(
  parameter int LENGTH     = 10,
  parameter int PRESCALE_W = 4
) (
  input  logic              clk,
  input  logic              arst_b,
  input  logic              start,
  input  logic              stop,
  input  logic              periodic,
  input  logic [LENGTH-1:0] period,
`ifdef COUNTER_CTRL_PRESCALER_EN
  input  logic [PRESCALE_W-1:0] prescale,
`endif
  input  logic              irq_ack,
  output logic [LENGTH-1:0] count,
  output logic              running,
  output logic              done,
  output logic              irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [LENGTH-1:0] period_q;
  logic              periodic_q;

  logic tick;
  logic start_ok;
  logic at_end;
  logic term;

  // A start is accepted only outside RUN. It needs a non-zero period and no
  // concurrent stop.
  assign start_ok = start && !stop && (period != '0);
  assign at_end   = (count == period_q);
  // Terminal event: a tick lands while the count sits at the period.
  assign term     = (state == RUN) && !stop && tick && at_end;

`ifdef COUNTER_CTRL_PRESCALER_EN
  logic [PRESCALE_W-1:0] div_q;
  logic [PRESCALE_W-1:0] prescale_q;

  assign tick = (div_q == prescale_q);

  // The divider only advances in RUN. It sits at zero otherwise, so a start
  // always begins a full prescale+1 clock interval.
  always_ff @(posedge clk or negedge arst_b) begin
    if (!arst_b) begin
      div_q      <= '0;
      prescale_q <= '0;
    end else if (state != RUN || stop) begin
      div_q <= '0;
      if (state != RUN && start_ok) prescale_q <= prescale;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end
`else
  assign tick = 1'b1;
  logic unused_prescale_w;
  assign unused_prescale_w = |PRESCALE_W;
`endif

  always_ff @(posedge clk or negedge arst_b) begin
    if (!arst_b) begin
      state      <= IDLE;
      period_q   <= '0;
      periodic_q <= 1'b0;
      count      <= '0;
      running    <= 1'b0;
      done       <= 1'b0;
      irq        <= 1'b0;
    end else begin
      done <= term;
      // A done pulse that is still visible also counts as a set. An ack that
      // overlaps either the terminal edge or the done cycle is therefore lost.
      irq  <= term | done | (irq & ~irq_ack);

      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            period_q   <= period;
            periodic_q <= periodic;
            count      <= '0;
            state      <= RUN;
            running    <= 1'b1;
          end else if (stop) begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (stop) begin
            // The count freezes where it is.
            state   <= IDLE;
            running <= 1'b0;
          end else if (tick) begin
            if (!at_end) begin
              count <= count + 1'b1;
            end else if (periodic_q) begin
              count <= '0;
            end else begin
              state   <= DONE;
              running <= 1'b0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_counter_ctrl
//
// Self-checking bench for counter_ctrl. Directed scenarios are followed by
// randomized traffic. Every output is compared each cycle against a
// behavioural model of the run/terminal/interrupt rules. Define
// COUNTER_CTRL_PRESCALER_EN on both files to exercise the prescaler.
// -----------------------------------------------------------------------------
module tb_counter_ctrl;
  localparam int LENGTH     = 10;
  localparam int PRESCALE_W = 4;

  logic              clk;
  logic              arst_b;
  logic              start;
  logic              stop;
  logic              periodic;
  logic [LENGTH-1:0] period;
  logic              irq_ack;
  logic [LENGTH-1:0] count;
  logic              running;
  logic              done;
  logic              irq;
  logic [PRESCALE_W-1:0] prescale;

  counter_ctrl #(.LENGTH(LENGTH), .PRESCALE_W(PRESCALE_W)) dut (
    .clk      (clk),
    .arst_b   (arst_b),
    .start    (start),
    .stop     (stop),
    .periodic (periodic),
    .period   (period),
`ifdef COUNTER_CTRL_PRESCALER_EN
    .prescale (prescale),
`endif
    .irq_ack  (irq_ack),
    .count    (count),
    .running  (running),
    .done     (done),
    .irq      (irq)
  );

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- scoreboard
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  // IDLE and DONE react identically to start/stop, so the model only tracks
  // whether a run is active. The count is plain integer arithmetic.
  int unsigned m_count, m_period, m_div, m_pre;
  bit          m_periodic, m_running, m_done, m_irq;

  task automatic model_reset();
    m_count = 0; m_period = 0; m_div = 0; m_pre = 0;
    m_periodic = 0; m_running = 0; m_done = 0; m_irq = 0;
  endtask

  // Apply one rising edge using the inputs that are currently driven.
  task automatic model_edge();
    bit ev;
    ev = 0;
    if (m_running) begin
      if (stop) begin
        m_running = 0;
        m_div     = 0;
      end else if (m_div == m_pre) begin
        m_div = 0;
        if (m_count < m_period) m_count = m_count + 1;
        else begin
          ev = 1;
          if (m_periodic) m_count = 0;
          else m_running = 0;
        end
      end else begin
        m_div = m_div + 1;
      end
    end else if (!stop && start && period != 0) begin
      m_period   = period;
      m_periodic = periodic;
      m_pre      = prescale;
      m_count    = 0;
      m_div      = 0;
      m_running  = 1;
    end
    m_irq  = ev || m_done || (m_irq && !irq_ack);
    m_done = ev;
  endtask

  task automatic compare_all();
    check("count",   32'(count),   m_count);
    check("running", 32'(running), 32'(m_running));
    check("done",    32'(done),    32'(m_done));
    check("irq",     32'(irq),     32'(m_irq));
  endtask

  // ---------------------------------------------------------------- driver
  task automatic step(input bit s, input bit p, input bit per, input int unsigned prd, input bit ack);
    @(negedge clk);
    start    = s;
    stop     = p;
    periodic = per;
    period   = prd[LENGTH-1:0];
    irq_ack  = ack;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int cyc;
    arst_b = 1'b0; start = 0; stop = 0; periodic = 0; period = '0; irq_ack = 0;
    prescale = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all();                       // reset values
    @(negedge clk) arst_b = 1'b1;
    idle(2);

    // One-shot, period 3: count 0,1,2,3, done/irq one edge later.
    step(1, 0, 0, 3, 0);
    check("os_run", 32'(running), 32'd1);
    idle(3);
    check("os_cnt3", 32'(count), 32'd3);
    idle(1);
    check("os_done", 32'(done), 32'd1);
    check("os_irq",  32'(irq),  32'd1);
    check("os_stopped", 32'(running), 32'd0);
    idle(2);
    check("os_hold", 32'(count), 32'd3);
    step(0, 0, 0, 0, 1);                 // ack clears irq
    check("ack_clr", 32'(irq), 32'd0);

    // Boundaries: zero period, start+stop together.
    step(1, 0, 1, 0, 0);
    check("zero_per", 32'(running), 32'd0);
    step(1, 1, 0, 5, 0);
    check("start_stop", 32'(running), 32'd0);

    // Periodic, period 2, with an ignored start mid-run.
    step(1, 0, 1, 2, 0);
    idle(1);
    step(1, 0, 0, 7, 0);                 // ignored while running
    idle(1);                             // count wraps to 0, done
    check("per_wrap", 32'(count), 32'd0);
    check("per_done", 32'(done),  32'd1);
    step(0, 0, 0, 0, 1);                 // ack during the done cycle: set wins
    check("ack_vs_done", 32'(irq), 32'd1);
    step(0, 0, 0, 0, 1);
    check("ack_next", 32'(irq), 32'd0);
    step(0, 0, 0, 0, 1);                 // ack on the terminal edge: set wins
    check("ack_vs_term", 32'(irq), 32'd1);
    idle(4);
    step(0, 1, 0, 0, 0);
    check("per_stop", 32'(running), 32'd0);
    idle(2);

    // Asynchronous reset mid-run at count 5.
    step(1, 0, 0, 20, 0);
    idle(5);
    check("pre_rst", 32'(count), 32'd5);
    @(negedge clk);
    #2 arst_b = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk) arst_b = 1'b1;
    idle(2);

`ifdef COUNTER_CTRL_PRESCALER_EN
    // prescale 2, period 1, one-shot: done six clocks after the start edge.
    prescale = 4'd2;
    step(1, 0, 0, 1, 0);
    cyc = 0;
    while (!done && cyc < 20) begin
      idle(1);
      cyc++;
    end
    check("presc_lat", 32'(cyc), 32'd6);
    prescale = '0;
    idle(2);
`else
    cyc = 0;
`endif

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      bit s, p, per, ack;
      int unsigned prd;
      s   = ($urandom_range(0, 7) == 0);
      p   = ($urandom_range(0, 15) == 0);
      per = $urandom_range(0, 1);
      ack = ($urandom_range(0, 3) == 0);
      prd = ($urandom_range(0, 9) == 0) ? $urandom_range(0, (1 << LENGTH) - 1)
                                        : $urandom_range(0, 6);
`ifdef COUNTER_CTRL_PRESCALER_EN
      prescale = PRESCALE_W'($urandom_range(0, 3));
`endif
      step(s, p, per, prd, ack);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Run controller for the free-running `LENGTH`-bit counter datapath. It starts, stops and terminates a count against a programmable period in one-shot or periodic mode, and raises a sticky interrupt with an acknowledge handshake. It sits between the register/host interface and the counter, replacing a bare free-running counter wherever software needs a bounded or repeating count.

## Interface
- `LENGTH`, default 10: counter and period width in bits.
- `PRESCALE_W`, default 4: prescaler divide-field width. Used only with `COUNTER_CTRL_PRESCALER_EN`.
- `clk` input 1: clock, all logic on the rising edge.
- `arst_b` input 1: reset, asynchronous, active-low.
- `start` input 1: single-cycle request to begin a run.
- `stop` input 1: single-cycle request to abort a run.
- `periodic` input 1: 1 selects periodic mode, 0 selects one-shot. Sampled with `start`.
- `period` input `LENGTH`: terminal count. Sampled with `start`.
- `prescale` input `PRESCALE_W`: tick divider. Present only with the macro defined.
- `irq_ack` input 1: clears `irq`.
- `count` output `LENGTH`: current count value.
- `running` output 1: high in state RUN.
- `done` output 1: one-cycle pulse on each terminal event.
- `irq` output 1: sticky terminal-event flag.

## Operation
- Reset value of every output is 0. On reset the FSM enters IDLE, the latched period is 0, and the mode is one-shot.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `start` with `period != 0`: latch `period` and `periodic`, set count to 0, go to RUN.
  - `start` with `period == 0`: ignored, no state change.
- RUN, on each tick:
  - If count ≠ latched period: count increments by 1.
  - If count = latched period and mode is periodic: count becomes 0, `done` pulses, stay in RUN.
  - If count = latched period and mode is one-shot: count holds at the period, `done` pulses, go to DONE.
- RUN, on `stop`: go to IDLE. Count freezes at its current value and no `done` is produced.
- DONE: count holds. `start` restarts the run exactly as from IDLE. `stop` moves to IDLE.
- `start` while in RUN is ignored; the period and mode cannot change mid-run.
- `start` and `stop` in the same cycle: `stop` wins and `start` is dropped.
- `irq` is set by `done` and cleared by `irq_ack`. If both occur in the same cycle, set wins and `irq` stays 1.
- Arithmetic is unsigned modulo 2^`LENGTH`. Overflow cannot occur because the count never exceeds the latched period.
- Reset asserted mid-run returns everything to reset values immediately (asynchronously). No `done` pulse is generated.

## Timing
- `start` sampled at edge N:
  - `running` = 1 and count = 0 after edge N.
  - count = k after edge N+k.
- Periodic mode, period P:
  - count reads P after edge N+P.
  - count reads 0 and `done` = 1 after edge N+P+1.
  - Repeat rate is P+1 ticks.
- One-shot mode, period P:
  - `done` = 1 and `running` = 0 after edge N+P+1.
  - count stays at P.
- `done` is registered and high for exactly one clock.
- `irq` rises in the same cycle as `done`.
- `irq_ack` sampled at edge M gives `irq` = 0 after edge M.
- `stop` sampled at edge M gives `running` = 0 after edge M.

## Configuration
- Macro: `COUNTER_CTRL_PRESCALER_EN`.
- Defined:
  - The `prescale` port and a `PRESCALE_W`-bit divider are present.
  - One tick occurs every `prescale`+1 clocks while in RUN.
  - The divider clears on `start`, on `stop` and on reset.
  - `prescale` is sampled with `start`.
  - Timing figures above scale by (`prescale`+1) clocks per tick.
- Undefined:
  - The port and divider are absent.
  - Every clock in RUN is a tick.

## Test plan
- Reset: `arst_b` = 0 mid-run at count 5 → `count` = 0 and `running`, `done`, `irq` = 0 asynchronously; after release the block is in IDLE.
- One-shot, `period` = 3: `start` at edge N → count 0,1,2,3. `done` and `irq` = 1 after edge N+4, `running` = 0, count holds at 3.
- Periodic, `period` = 2: count 0,1,2,0,1,2,0 with a `done` pulse on every return to 0. `stop` gives `running` = 0 with count frozen.
- Boundaries:
  - `start` with `period` = 0 → no change.
  - `start` + `stop` in the same cycle → stays in IDLE.
  - `start` during RUN → ignored.
- `irq_ack` in the same cycle as `done` → `irq` stays 1. The next `irq_ack` gives `irq` = 0.
- With `COUNTER_CTRL_PRESCALER_EN` defined, `prescale` = 2, `period` = 1, one-shot → `done` after 6 clocks, following the `start` edge.
